score_bcd_display: RTL and testbench

Sequential, parametrised score display driver. It accepts a binary score through a valid/ready handshake and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It then latches the result and drives DIGITS active-low seven-segment outputs with optional leading-zero blanking and overflow indication. It sits between the game score register and the board HEX displays. Static label glyphs stay in the top-level wrapper.

---
 rtl/score_disp_pkg.sv | 23 ++
 rtl/seg7_digit_decode.sv | 21 ++
 rtl/score_bcd_display.sv | 124 ++++++++++++
 tb/tb_score_bcd_display.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display: segment glyphs, FSM states and
// the double-dabble nibble adjust.
package score_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StLoad
  } state_e;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [3:0] add3_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// One seven-segment digit: BCD nibble to active-low glyph, with dash and
// blank overrides (dash wins).
module seg7_digit_decode
  import score_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i && (nibble_i <= 4'd9)) begin
      seg_o = SEG_DIGIT[nibble_i];
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// Score display driver: handshaked binary input, one-bit-per-clock
// double-dabble conversion, latched display with blanking and overflow dash.
module score_bcd_display
  import score_disp_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned DIGITS   = 4,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      score_in,
  input  logic                  score_valid,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic [BcdW-1:0]   disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  always_comb begin
    for (int k = 0; k < int'(DIGITS); k++) begin
      bcd_adj[4*k +: 4] = add3_adj(bcd_q[4*k +: 4]);
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    disp_d   = disp_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (score_valid) begin
          bin_d    = score_in;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CntW'(WIDTH);
          state_d  = StConvert;
        end
      end
      StConvert: begin
        {bcd_d, bin_d} = {bcd_adj[BcdW-2:0], bin_q, 1'b0};
        // A one leaving the top nibble means the value cannot fit in DIGITS.
        sticky_d = sticky_q | bcd_adj[BcdW-1];
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        disp_d  = bcd_q;
        ovf_d   = sticky_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign done     = done_q;
  assign overflow = ovf_q;

  // Digit k blanks when it and every digit above it are zero; digit 0 never blanks.
  logic [DIGITS-1:0] blank;
  logic              zero_run;

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_run = zero_run & (disp_q[4*k +: 4] == 4'd0);
      blank[k] = LZ_BLANK & zero_run;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_digit
    seg7_digit_decode u_dec (
      .nibble_i (disp_q[4*g +: 4]),
      .blank_i  (blank[g]),
      .dash_i   (ovf_q),
      .seg_o    (hex_out[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display across four parameter sets sharing
// one clock and reset.
module tb_score_bcd_display;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [6:0] GD = 7'b0111111;

  // 0: W12 D4 LZ1, 1: W14 D4 LZ1, 2: W14 D4 LZ0, 3: W12 D3 LZ1
  logic        clk, rst;
  logic [13:0] score [4];
  logic        valid [4];
  logic        ready [4];
  logic        done  [4];
  logic        ovf   [4];
  logic [27:0] hex   [4];
  logic [20:0] hex_3;

  int n_checks = 0;
  int n_err    = 0;

  assign hex[3] = {7'b0, hex_3};

  score_bcd_display #(.WIDTH(12), .DIGITS(4), .LZ_BLANK(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .score_in(score[0][11:0]), .score_valid(valid[0]),
    .ready(ready[0]), .done(done[0]), .overflow(ovf[0]), .hex_out(hex[0])
  );
  score_bcd_display #(.WIDTH(14), .DIGITS(4), .LZ_BLANK(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .score_in(score[1]), .score_valid(valid[1]),
    .ready(ready[1]), .done(done[1]), .overflow(ovf[1]), .hex_out(hex[1])
  );
  score_bcd_display #(.WIDTH(14), .DIGITS(4), .LZ_BLANK(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .score_in(score[2]), .score_valid(valid[2]),
    .ready(ready[2]), .done(done[2]), .overflow(ovf[2]), .hex_out(hex[2])
  );
  score_bcd_display #(.WIDTH(12), .DIGITS(3), .LZ_BLANK(1'b1)) u_dut_d (
    .clk(clk), .rst(rst), .score_in(score[3][11:0]), .score_valid(valid[3]),
    .ready(ready[3]), .done(done[3]), .overflow(ovf[3]), .hex_out(hex_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accepts val on instance idx, waits (bounded) for done and checks latency,
  // the displayed glyphs, overflow and that done lasts one cycle.
  task automatic convert(input int idx, input logic [13:0] val, input int width,
                         input logic [27:0] exp_hex, input logic exp_ovf, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    check({tag, " ready"}, 28'(ready[idx]), 28'd1);
    score[idx] = val;
    valid[idx] = 1'b1;
    @(posedge clk);
    #1 valid[idx] = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done[idx]) seen = 1'b1;
    end
    check({tag, " latency"}, 28'(lat), 28'(width + 1));
    check({tag, " hex"}, hex[idx], exp_hex);
    check({tag, " ovf"}, 28'(ovf[idx]), 28'(exp_ovf));
    @(posedge clk);
    #1 check({tag, " done pulse"}, 28'(done[idx]), 28'd0);
  endtask

  initial begin
    int ndone, first, second;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      score[i] = '0;
    end
    #12;
    check("rst a hex", hex[0], {GB, GB, GB, G0});
    check("rst c hex", hex[2], {G0, G0, G0, G0});
    check("rst d hex", hex[3], {7'b0, GB, GB, G0});
    check("rst a ready", 28'(ready[0]), 28'd1);
    check("rst a ovf", 28'(ovf[0]), 28'd0);
    check("rst a done", 28'(done[0]), 28'd0);
    @(negedge clk);
    rst = 1'b0;

    convert(0, 14'd255,  12, {GB, G2, G5, G5}, 1'b0, "a255");
    convert(0, 14'd105,  12, {GB, G1, G0, G5}, 1'b0, "a105");
    convert(0, 14'd0,    12, {GB, GB, GB, G0}, 1'b0, "a0");
    convert(1, 14'd9999, 14, {G9, G9, G9, G9}, 1'b0, "b9999");
    convert(1, 14'd1000, 14, {G1, G0, G0, G0}, 1'b0, "b1000");
    convert(2, 14'd7,    14, {G0, G0, G0, G7}, 1'b0, "c7");
    convert(3, 14'd4095, 12, {7'b0, GD, GD, GD}, 1'b1, "d4095");
    convert(3, 14'd999,  12, {7'b0, G9, G9, G9}, 1'b0, "d999");

    // Valid held high through a conversion: second value waits for ready.
    @(negedge clk);
    score[0] = 14'd123;
    valid[0] = 1'b1;
    @(posedge clk);
    #1 score[0] = 14'd456;
    ndone  = 0;
    first  = 0;
    second = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (e == 13) begin
        check("hold hex 123", hex[0], {GB, G1, G2, G3});
        check("hold ready back", 28'(ready[0]), 28'd1);
      end
      if (e == 14) begin
        check("hold reaccept", 28'(ready[0]), 28'd0);
        valid[0] = 1'b0;
      end
      if (done[0]) begin
        ndone++;
        if (first == 0) first = e;
        else if (second == 0) second = e;
      end
    end
    check("hold first done", 28'(first), 28'd13);
    check("hold second done", 28'(second), 28'd27);
    check("hold done count", 28'(ndone), 28'd2);
    check("hold hex 456", hex[0], {GB, G4, G5, G6});

    // Reset in the middle of a conversion.
    @(negedge clk);
    score[0] = 14'd321;
    valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("abort hex held", hex[0], {GB, G4, G5, G6});
    rst = 1'b1;
    #1;
    check("abort hex", hex[0], {GB, GB, GB, G0});
    check("abort ready", 28'(ready[0]), 28'd1);
    check("abort ovf", 28'(ovf[0]), 28'd0);
    ndone = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1 if (done[0]) ndone++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      #1 if (done[0]) ndone++;
    end
    check("abort no done", 28'(ndone), 28'd0);
    convert(0, 14'd42, 12, {GB, GB, G4, G2}, 1'b0, "a42");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
